ta_jump_ctrl: RTL and testbench

Sequences the TA sprite's vertical motion by generating the `jump` level consumed by the TA position block. It converts a synchronized button level into a timed rise phase of JUMP_TICKS frame ticks, then a fall phase. A new jump is allowed only when the sprite is grounded, i.e. the fed-back vertical position equals BOTTOM. It sits between keyboard/button decode and the TA position block, and is advanced by the same frame tick that paces sprite motion.

---
 rtl/ta_jump_ctrl.sv | 156 +++++++++++++++
 tb/tb_ta_jump_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/ta_jump_ctrl.sv
// TA sprite jump sequencer: button press -> timed rise of JUMP_TICKS frame ticks -> fall -> land.
// Optional TA_DOUBLE_JUMP_EN allows one extra airborne jump per flight.
module ta_jump_ctrl #(
  parameter int JUMP_TICKS = 40,
  parameter int BOTTOM     = 420,
  parameter int UP_BORDER  = 20,
  parameter int CNT_W      = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             btn,
  input  logic             freeze,
  input  logic [9:0]       ta_v,
  output logic             jump,
  output logic             grounded,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] rise_left
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RISE = 2'd1,
    FALL = 2'd2,
    UNUSED = 2'd3
  } state_t;

  localparam logic [9:0]       BOTTOM_V  = 10'(BOTTOM);
  localparam logic [9:0]       BORDER_V  = 10'(UP_BORDER);
  localparam logic [CNT_W-1:0] RISE_INIT = CNT_W'(JUMP_TICKS - 1);

  state_t           state_reg, state_next;
  logic             jump_reg, jump_next;
  logic             grounded_reg, grounded_next;
  logic [CNT_W-1:0] rise_left_reg, rise_left_next;
  logic             btn_q_reg;
  logic             pend_reg;
  logic             press;
  logic             step;
  logic             req;
  logic             at_bottom;
  logic             at_border;

  assign press     = btn & ~btn_q_reg;
  assign step      = tick & ~freeze;
  assign req       = pend_reg | press;
  assign at_bottom = (ta_v == BOTTOM_V);
  assign at_border = (ta_v == BORDER_V);

  // btn_q resets high so a button held through reset is not seen as a press.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_q_reg <= 1'b1;
      pend_reg  <= 1'b0;
    end else begin
      btn_q_reg <= btn;
      if (!freeze) begin
        if (tick)
          pend_reg <= 1'b0;
        else if (press)
          pend_reg <= 1'b1;
      end
    end
  end

`ifdef TA_DOUBLE_JUMP_EN
  logic air_used_reg, air_used_next;

  always_ff @(posedge clk) begin
    if (rst)
      air_used_reg <= 1'b0;
    else
      air_used_reg <= air_used_next;
  end
`endif

  always_comb begin
    state_next     = state_reg;
    jump_next      = jump_reg;
    rise_left_next = rise_left_reg;
`ifdef TA_DOUBLE_JUMP_EN
    air_used_next  = air_used_reg;
`endif
    if (step) begin
      case (state_reg)
        IDLE: begin
`ifdef TA_DOUBLE_JUMP_EN
          air_used_next = 1'b0;
`endif
          if (req && at_bottom) begin
            state_next     = RISE;
            jump_next      = 1'b1;
            rise_left_next = RISE_INIT;
          end
        end
        RISE: begin
          if (at_border) begin
            state_next = FALL;
            jump_next  = 1'b0;
`ifdef TA_DOUBLE_JUMP_EN
          end else if (req && !air_used_reg) begin
            rise_left_next = RISE_INIT;
            air_used_next  = 1'b1;
`endif
          end else if (rise_left_reg == '0) begin
            state_next = FALL;
            jump_next  = 1'b0;
          end else begin
            rise_left_next = rise_left_reg - 1'b1;
          end
        end
        FALL: begin
          jump_next = 1'b0;
`ifdef TA_DOUBLE_JUMP_EN
          if (req && !air_used_reg && !at_border) begin
            state_next     = RISE;
            jump_next      = 1'b1;
            rise_left_next = RISE_INIT;
            air_used_next  = 1'b1;
          end else if (at_bottom) begin
            state_next = IDLE;
          end
`else
          if (at_bottom)
            state_next = IDLE;
`endif
        end
        default: begin
          state_next = IDLE;
          jump_next  = 1'b0;
        end
      endcase
    end
    grounded_next = (state_next == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      jump_reg      <= 1'b0;
      grounded_reg  <= 1'b1;
      rise_left_reg <= '0;
    end else begin
      state_reg     <= state_next;
      jump_reg      <= jump_next;
      grounded_reg  <= grounded_next;
      rise_left_reg <= rise_left_next;
    end
  end

  assign jump      = jump_reg;
  assign grounded  = grounded_reg;
  assign state     = state_reg;
  assign rise_left = rise_left_reg;

endmodule

// File: tb/tb_ta_jump_ctrl.sv
// Directed bench for ta_jump_ctrl: reset, full rise, border cut, air/ungrounded presses, freeze, mid-jump reset.
module tb_ta_jump_ctrl;

  localparam int CNT_W = 10;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             tick = 1'b0;
  logic             btn = 1'b1;
  logic             freeze = 1'b0;
  logic [9:0]       ta_v = 10'd420;
  logic             jump;
  logic             grounded;
  logic [1:0]       state;
  logic [CNT_W-1:0] rise_left;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ta_jump_ctrl #(
    .JUMP_TICKS(40),
    .BOTTOM(420),
    .UP_BORDER(20),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .tick(tick),
    .btn(btn),
    .freeze(freeze),
    .ta_v(ta_v),
    .jump(jump),
    .grounded(grounded),
    .state(state),
    .rise_left(rise_left)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  // One tick pulse; returns at the falling edge after the edge that sampled it.
  task automatic do_tick();
    @(negedge clk) tick = 1'b1;
    @(negedge clk) tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) do_tick();
  endtask

  // Rising edge of btn between ticks; latched into pend.
  task automatic press();
    @(negedge clk) btn = 1'b0;
    @(negedge clk) btn = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    // 1: reset with button held
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_state", state, 0);
    check("rst_jump", jump, 0);
    check("rst_grounded", grounded, 1);
    check("rst_rise_left", rise_left, 0);
    ticks(5);
    check("held_btn_state", state, 0);
    check("held_btn_jump", jump, 0);

    // 2: full-length rise
    press();
    do_tick();
    check("start_jump", jump, 1);
    check("start_rise_left", rise_left, 39);
    check("start_state", state, 1);
    check("start_grounded", grounded, 0);
    for (int i = 0; i < 39; i++) do_tick();
    check("rise_end_jump", jump, 1);
    check("rise_end_rise_left", rise_left, 0);
    do_tick();
    check("fall_state", state, 2);
    check("fall_jump", jump, 0);

    // 4 (air part): press while falling
    ta_v = 10'd300;
    press();
    do_tick();
`ifdef TA_DOUBLE_JUMP_EN
    check("air1_state", state, 1);
    check("air1_rise_left", rise_left, 39);
    press();
    do_tick();
    check("air2_state", state, 1);
    check("air2_rise_left", rise_left, 38);
    ta_v = 10'd20;
    do_tick();
    check("air_border_state", state, 2);
`else
    check("air_press_state", state, 2);
    check("air_press_jump", jump, 0);
`endif
    ta_v = 10'd420;
    do_tick();
    check("land_state", state, 0);
    check("land_grounded", grounded, 1);

    // 3: UP_BORDER cuts the rise short
    press();
    do_tick();
    ticks(14);
    check("cut_rise_left", rise_left, 25);
    ta_v = 10'd20;
    do_tick();
    check("cut_state", state, 2);
    check("cut_jump", jump, 0);
    ta_v = 10'd420;
    do_tick();
    check("cut_land_state", state, 0);
    check("cut_land_grounded", grounded, 1);

    // 4: press while not at BOTTOM is discarded, pend does not survive
    ta_v = 10'd300;
    press();
    do_tick();
    check("ungrounded_state", state, 0);
    check("ungrounded_jump", jump, 0);
    ta_v = 10'd420;
    do_tick();
    check("pend_cleared_state", state, 0);

    // press coinciding with the tick is used by that tick
    @(negedge clk) btn = 1'b0;
    @(negedge clk) begin btn = 1'b1; tick = 1'b1; end
    @(negedge clk) tick = 1'b0;
    check("same_cycle_state", state, 1);
    check("same_cycle_rise_left", rise_left, 39);

    // 5: freeze mid-rise
    ticks(22);
    check("pre_freeze_rise_left", rise_left, 17);
    freeze = 1'b1;
    ticks(10);
    check("frozen_rise_left", rise_left, 17);
    check("frozen_jump", jump, 1);
    check("frozen_state", state, 1);
    freeze = 1'b0;
    do_tick();
    check("resume_rise_left", rise_left, 16);

    // 6: reset mid-jump
    ticks(6);
    check("pre_rst_rise_left", rise_left, 10);
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    check("mid_rst_state", state, 0);
    check("mid_rst_jump", jump, 0);
    check("mid_rst_rise_left", rise_left, 0);
    check("mid_rst_grounded", grounded, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
